// File: rtl/wb_queue.sv
// Write-back queue: buffers register-file writes in a circular FIFO,
// drains them in order and forwards the newest pending value to reads.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_addr,
  input  logic [DW-1:0] in_data,
  input  logic          drain_en,
  output logic          rf_write,
  output logic [4:0]    rf_wraddr,
  output logic [DW-1:0] rf_wrdata,
  input  logic [4:0]    rd_addr1,
  input  logic [4:0]    rd_addr2,
  output logic          fwd_hit1,
  output logic          fwd_hit2,
  output logic [DW-1:0] fwd_data1,
  output logic [DW-1:0] fwd_data2,
  output logic [CW-1:0] count
);

  localparam int PW = CW - 1;

  logic [4:0]    addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic push;
  logic pop;
  logic empty;
  logic full;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  assign in_ready = !full && !rst;
  assign rf_write = !empty && drain_en && !rst;

  assign push = in_valid && in_ready;
  assign pop  = rf_write;

  assign rf_wraddr = empty ? '0 : addr_q[head_q];
  assign rf_wrdata = empty ? '0 : data_q[head_q];

  assign count = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= in_addr;
      data_q[tail_q] <= in_data;
    end
  end

  // Scan oldest to newest so the last match (closest to tail) wins.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        if (addr_q[head_q + PW'(i)] == rd_addr1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = data_q[head_q + PW'(i)];
        end
        if (addr_q[head_q + PW'(i)] == rd_addr2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = data_q[head_q + PW'(i)];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: queue-based reference model checked every cycle,
// plus directed vectors with literal expected values.
module tb_wb_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int CW    = 3;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_addr;
  logic [DW-1:0] in_data;
  logic          drain_en;
  logic          rf_write;
  logic [4:0]    rf_wraddr;
  logic [DW-1:0] rf_wrdata;
  logic [4:0]    rd_addr1;
  logic [4:0]    rd_addr2;
  logic          fwd_hit1;
  logic          fwd_hit2;
  logic [DW-1:0] fwd_data1;
  logic [DW-1:0] fwd_data2;
  logic [CW-1:0] count;

  wb_queue #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .drain_en  (drain_en),
    .rf_write  (rf_write),
    .rf_wraddr (rf_wraddr),
    .rf_wrdata (rf_wrdata),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0]    a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  bit   started = 0;

  always @(posedge clk) begin
    bit do_pop;
    bit do_push;
    ent_t e;
    if (rst) begin
      q.delete();
    end else begin
      do_pop  = (q.size() > 0) && drain_en;
      do_push = in_valid && (q.size() < DEPTH);
      e.a = in_addr;
      e.d = in_data;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
    started = 1;
  end

  always @(negedge clk) begin
    logic          h1, h2;
    logic [DW-1:0] d1, d2;
    logic [4:0]    wa;
    logic [DW-1:0] wd;
    if (started) begin
      h1 = 0; h2 = 0; d1 = '0; d2 = '0;
      foreach (q[j]) begin
        if (q[j].a == rd_addr1) begin h1 = 1; d1 = q[j].d; end
        if (q[j].a == rd_addr2) begin h2 = 1; d2 = q[j].d; end
      end
      wa = (q.size() > 0) ? q[0].a : 5'd0;
      wd = (q.size() > 0) ? q[0].d : '0;
      chk("m_count", 32'(count), 32'(q.size()));
      chk("m_ready", 32'(in_ready), 32'((q.size() < DEPTH) && !rst));
      chk("m_write", 32'(rf_write), 32'((q.size() > 0) && drain_en && !rst));
      chk("m_wraddr", 32'(rf_wraddr), 32'(wa));
      chk("m_wrdata", rf_wrdata, wd);
      chk("m_hit1", 32'(fwd_hit1), 32'(h1));
      chk("m_hit2", 32'(fwd_hit2), 32'(h2));
      chk("m_data1", fwd_data1, d1);
      chk("m_data2", fwd_data2, d2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    tick();
  endtask

  initial begin
    int exp_ord[8] = '{1, 2, 10, 11, 12, 13, 14, 15};
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
    drain_en = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
    tick(); tick();
    drain_en = 1'b1;
    mid();
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_write", 32'(rf_write), 0);
    tick();

    rst = 1'b0;
    mid();
    chk("po_count", 32'(count), 0);
    chk("po_ready", 32'(in_ready), 1);
    chk("po_wraddr", 32'(rf_wraddr), 0);
    chk("po_wrdata", rf_wrdata, 0);
    chk("po_hit1", 32'(fwd_hit1), 0);
    chk("po_hit2", 32'(fwd_hit2), 0);
    chk("po_data1", fwd_data1, 0);
    chk("po_data2", fwd_data2, 0);
    tick();

    // basic write, one-cycle latency
    in_valid = 1'b1; in_addr = 5'd5; in_data = 32'hDEADBEEF;
    mid();
    chk("bw_nobypass", 32'(rf_write), 0);
    tick();
    in_valid = 1'b0;
    mid();
    chk("bw_write", 32'(rf_write), 1);
    chk("bw_wraddr", 32'(rf_wraddr), 5);
    chk("bw_wrdata", rf_wrdata, 32'hDEADBEEF);
    tick();
    mid();
    chk("bw_write2", 32'(rf_write), 0);
    chk("bw_count", 32'(count), 0);
    tick();

    // fill and stall
    drain_en = 1'b0;
    for (int k = 1; k <= 4; k++) push(5'(k), 32'(k * 'h11));
    in_addr = 5'd9; in_data = 32'h99;
    mid();
    chk("fs_count", 32'(count), 4);
    chk("fs_ready", 32'(in_ready), 0);
    tick();
    in_valid = 1'b0;
    mid();
    chk("fs_count5", 32'(count), 4);
    chk("fs_stall", 32'(rf_write), 0);
    tick();
    drain_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      mid();
      chk("fs_write", 32'(rf_write), 1);
      chk("fs_wraddr", 32'(rf_wraddr), 32'(k));
      chk("fs_wrdata", rf_wrdata, 32'(k * 'h11));
      if (k > 1) chk("fs_ready1", 32'(in_ready), 1);
      tick();
    end
    mid();
    chk("fs_empty", 32'(count), 0);
    tick();

    // forward newest
    drain_en = 1'b0;
    push(5'd7, 32'hA);
    push(5'd7, 32'hB);
    push(5'd3, 32'hC);
    in_valid = 1'b0; rd_addr1 = 5'd7; rd_addr2 = 5'd3;
    mid();
    chk("fw_hit1", 32'(fwd_hit1), 1);
    chk("fw_data1", fwd_data1, 32'hB);
    chk("fw_hit2", 32'(fwd_hit2), 1);
    chk("fw_data2", fwd_data2, 32'hC);
    rd_addr1 = 5'd9; #1;
    chk("fw_miss_hit", 32'(fwd_hit1), 0);
    chk("fw_miss_data", fwd_data1, 0);
    rd_addr1 = 5'd3; #1;
    chk("fw_same1", fwd_data1, 32'hC);
    chk("fw_same2", fwd_data2, 32'hC);
    in_valid = 1'b1; in_addr = 5'd3; in_data = 32'hD; #1;
    chk("fw_no_in", fwd_data2, 32'hC);
    tick();
    in_valid = 1'b0; drain_en = 1'b1; rd_addr1 = 5'd7;
    mid();
    chk("fw_head", fwd_data1, 32'hB);
    chk("fw_new3", fwd_data2, 32'hD);
    for (int k = 0; k < 4; k++) tick();
    mid();
    chk("fw_empty", 32'(count), 0);
    tick();

    // simultaneous push/pop with pointer wrap
    drain_en = 1'b0;
    push(5'd1, 32'h100);
    push(5'd2, 32'h200);
    drain_en = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_addr = 5'(10 + i); in_data = 32'(32'h1000 + i);
      mid();
      chk("pp_count", 32'(count), 2);
      chk("pp_order", 32'(rf_wraddr), 32'(exp_ord[i]));
      tick();
    end
    in_valid = 1'b0;
    for (int i = 6; i < 8; i++) begin
      mid();
      chk("pp_tail", 32'(rf_wraddr), 32'(exp_ord[i]));
      tick();
    end
    mid();
    chk("pp_empty", 32'(count), 0);
    tick();

    // reset mid-drain, push during reset dropped
    drain_en = 1'b0;
    push(5'd20, 32'h20);
    push(5'd21, 32'h21);
    push(5'd22, 32'h22);
    in_valid = 1'b0; drain_en = 1'b1;
    mid();
    chk("rd_first", 32'(rf_wraddr), 20);
    tick();
    rst = 1'b1; in_valid = 1'b1; in_addr = 5'd25; in_data = 32'h25;
    mid();
    chk("rd_write_rst", 32'(rf_write), 0);
    chk("rd_ready_rst", 32'(in_ready), 0);
    tick();
    rst = 1'b0; in_valid = 1'b0; rd_addr1 = 5'd21; rd_addr2 = 5'd25;
    mid();
    chk("rd_write", 32'(rf_write), 0);
    chk("rd_count", 32'(count), 0);
    chk("rd_hit1", 32'(fwd_hit1), 0);
    chk("rd_hit2", 32'(fwd_hit2), 0);
    tick();

    // address 0 is ordinary
    drain_en = 1'b0;
    push(5'd0, 32'h5A5A5A5A);
    in_valid = 1'b0; rd_addr1 = 5'd0;
    mid();
    chk("a0_hit", 32'(fwd_hit1), 1);
    chk("a0_data", fwd_data1, 32'h5A5A5A5A);
    chk("a0_nowrite", 32'(rf_write), 0);
    drain_en = 1'b1; #1;
    chk("a0_write", 32'(rf_write), 1);
    chk("a0_wraddr", 32'(rf_wraddr), 0);
    chk("a0_wrdata", rf_wrdata, 32'h5A5A5A5A);
    tick();
    mid();
    chk("a0_empty", 32'(count), 0);
    tick();

    // mixed traffic with a reset pulse, checked by the model
    for (int i = 0; i < 80; i++) begin
      in_valid = (i % 3) != 0;
      drain_en = (i % 5) < 2;
      in_addr  = 5'(i % 6);
      in_data  = 32'(i) * 32'h01010101;
      rd_addr1 = 5'(i % 6);
      rd_addr2 = 5'((i + 3) % 6);
      rst      = (i == 50);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; drain_en = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    mid();
    chk("end_empty", 32'(count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of pending write entries; legal values are powers of 2 from 2 to 16.
REQ-002 The block SHALL have parameter DW, default 32, giving the data width.
REQ-003 The block SHALL have parameter CW, default 3, giving the count width; it equals log2(DEPTH)+1.
REQ-004 clk  in  1  single clock; all state SHALL change on the rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 in_valid  in  1  upstream write request valid.
REQ-007 in_ready  out  1  queue can accept a request.
REQ-008 in_addr  in  5  destination register index.
REQ-009 in_data  in  DW  destination register data.
REQ-010 drain_en  in  1  register file accepts a write this cycle.
REQ-011 rf_write  out  1  write enable to the register file.
REQ-012 rf_wraddr  out  5  write address to the register file.
REQ-013 rf_wrdata  out  DW  write data to the register file.
REQ-014 rd_addr1, rd_addr2  in  5 each  read addresses being presented to the register file.
REQ-015 fwd_hit1, fwd_hit2  out  1 each  a pending entry matches the corresponding read address.
REQ-016 fwd_data1, fwd_data2  out  DW each  forwarded data for the corresponding read port.
REQ-017 count  out  CW  number of pending entries.

Function
REQ-018 The queue SHALL be a circular FIFO of DEPTH entries, each holding addr and data, with head and tail pointers that wrap modulo DEPTH.
REQ-019 in_ready SHALL equal (count < DEPTH) && !rst, and SHALL be derived from registered state only.
REQ-020 A push SHALL occur on an edge where in_valid && in_ready; the request is written at the tail, and the tail advances by 1.
REQ-021 rf_write SHALL equal (count > 0) && drain_en && !rst, combinationally.
REQ-022 rf_wraddr and rf_wrdata SHALL always show the head entry; when count == 0 they SHALL be 0.
REQ-023 A pop SHALL occur on every edge where rf_write == 1, and the head SHALL advance by 1; each entry is therefore written exactly once.
REQ-024 Latency: an entry pushed at edge N into an empty queue with drain_en=1 SHALL appear on rf_write/rf_wraddr/rf_wrdata in cycle N+1 (no same-cycle bypass from in_* to rf_*).
REQ-025 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-026 When full, in_ready=0 and no push SHALL occur even if a pop occurs in the same cycle.
REQ-027 When empty, no pop SHALL occur, and count SHALL never underflow or overflow.
REQ-028 While drain_en=0, the queue SHALL hold its entries, and rf_write SHALL be 0.
REQ-029 Address 0 SHALL be treated as an ordinary register; it is queued, written, and forwarded like any other.
REQ-030 For each read port k, fwd_hit_k SHALL be 1 if any pending entry (head included, even while it is being written) has addr == rd_addr_k.
REQ-031 On multiple matches, fwd_data_k SHALL be the data of the newest matching entry, that is, the one closest to the tail.
REQ-032 When fwd_hit_k=0, fwd_data_k SHALL be 0.
REQ-033 Forwarding SHALL be combinational from rd_addr_k and the registered queue state; in_data of the current cycle SHALL NOT be forwarded.
REQ-034 Forwarding ports 1 and 2 SHALL be independent; equal addresses on both ports SHALL give identical results.

Reset
REQ-035 When rst=1 at an edge, the head, tail, and count SHALL become 0, and all pending entries SHALL be discarded, including entries present mid-drain.
REQ-036 While rst=1, in_ready=0 and rf_write=0.
REQ-037 After reset, rf_wraddr=0, rf_wrdata=0, fwd_hit1=fwd_hit2=0, fwd_data1=fwd_data2=0, and count=0.
REQ-038 A push presented in the same cycle as rst=1 SHALL be dropped.

Verification
REQ-039 Basic write: reset, drain_en=1, push (addr=5, data=0xDEADBEEF) -> next cycle rf_write=1, rf_wraddr=5, rf_wrdata=0xDEADBEEF; following cycle rf_write=0 and count=0.
REQ-040 Fill and stall: drain_en=0, push addr 1..4 with data 0x11..0x44 -> count=4 and in_ready=0; a 5th push is ignored; drain_en=1 -> writes 1,2,3,4 in order over 4 cycles, with in_ready=1 after the first pop.
REQ-041 Forward newest: drain_en=0, push (7,0xA), (7,0xB), (3,0xC); rd_addr1=7, rd_addr2=3 -> fwd_hit1=1, fwd_data1=0xB, fwd_hit2=1, fwd_data2=0xC; rd_addr1=9 -> fwd_hit1=0, fwd_data1=0.
REQ-042 Simultaneous push/pop: count=2, drain_en=1, push every cycle for 6 cycles -> count stays 2, pointers wrap past DEPTH, and the write order matches the push order.
REQ-043 Reset mid-drain: count=3, drain_en=1, rst=1 for one cycle after the first write -> no further rf_write, count=0, fwd_hit1=fwd_hit2=0.
REQ-044 Address 0: push (0,0x5A5A5A5A) -> rf_write with rf_wraddr=0, and rd_addr1=0 gives fwd_hit1=1 with fwd_data1=0x5A5A5A5A before the write.
